// File: rtl/data_bus_hub.sv
// Data-bus slave: decodes core accesses to the external sync RAM or to the LED/switch/timer
// peripheral block, and returns read data with a uniform one-cycle latency.
module data_bus_hub #(
    parameter int          RAM_AW      = 12,
    parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
    parameter int          LED_W       = 16,
    parameter int          SW_W        = 16,
    parameter int          PRESCALE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_re,
    input  logic [3:0]        bus_we,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [LED_W-1:0]  led_out,
    input  logic [SW_W-1:0]   sw_in,
    output logic              timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_PERIPH} sel_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic             is_ram, is_periph, wr_p;
    logic [5:0]       off;
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [2:0]       ctrl_q;
    logic [31:0]      cnt_q, cmp_q;
    logic             match_q;
    logic [PW-1:0]    psc_q;
    logic             tick, hit;
    logic [31:0]      rd_val, periph_q;
    sel_t             sel_q;
    logic [31:0]      led_wr, ctrl_wr, cnt_wr, cmp_wr;
    logic             unused_addr_lsb;

    assign is_ram    = ~bus_addr[31];
    assign is_periph = (bus_addr[31:8] == PERIPH_BASE[31:8]);
    assign off       = bus_addr[7:2];
    assign wr_p      = is_periph & (|bus_we);
    assign unused_addr_lsb = ^bus_addr[1:0];

    assign ram_en    = is_ram & (bus_re | (|bus_we));
    assign ram_we    = is_ram ? bus_we : 4'b0;
    assign ram_addr  = bus_addr[RAM_AW+1:2];
    assign ram_wdata = bus_wdata;

    assign led_out   = led_q;
    assign timer_irq = match_q & ctrl_q[2];

    assign led_wr  = merge_bytes(32'(led_q), bus_wdata, bus_we);
    assign ctrl_wr = merge_bytes({29'b0, ctrl_q}, bus_wdata, bus_we);
    assign cnt_wr  = merge_bytes(cnt_q, bus_wdata, bus_we);
    assign cmp_wr  = merge_bytes(cmp_q, bus_wdata, bus_we);

    assign tick = ctrl_q[0] & (psc_q == PW'(PRESCALE - 1));
    assign hit  = (cnt_q == cmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= '0;
            ctrl_q <= '0;
            cmp_q  <= '0;
        end else if (wr_p) begin
            if (off == 6'h00) led_q  <= led_wr[LED_W-1:0];
            if (off == 6'h02) ctrl_q <= ctrl_wr[2:0];
            if (off == 6'h04) cmp_q  <= cmp_wr;
        end
    end

    // Software CNT write wins over a tick; MATCH set wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (ctrl_q[0]) psc_q <= tick ? '0 : psc_q + 1'b1;
            if (wr_p && off == 6'h03)
                cnt_q <= cnt_wr;
            else if (tick)
                cnt_q <= (hit && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
            if (tick && hit)
                match_q <= 1'b1;
            else if (wr_p && off == 6'h05 && bus_we[0] && bus_wdata[0])
                match_q <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            6'h00:   rd_val = 32'(led_q);
            6'h01:   rd_val = 32'(sw_s2);
            6'h02:   rd_val = {29'b0, ctrl_q};
            6'h03:   rd_val = cnt_q;
            6'h04:   rd_val = cmp_q;
            6'h05:   rd_val = {31'b0, match_q};
            default: rd_val = '0;
        endcase
    end

    // Peripheral value is captured with the select so it reflects pre-write state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= SEL_NONE;
            periph_q <= '0;
        end else begin
            if (bus_re)
                sel_q <= is_ram ? SEL_RAM : (is_periph ? SEL_PERIPH : SEL_NONE);
            else
                sel_q <= SEL_NONE;
            if (bus_re && is_periph) periph_q <= rd_val;
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (sel_q)
            SEL_RAM:    bus_rdata = ram_rdata;
            SEL_PERIPH: bus_rdata = periph_q;
            default:    bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_hub.sv
// Directed bench for data_bus_hub with a behavioural synchronous RAM attached.
module tb_data_bus_hub;

    localparam logic [31:0] PB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_re = 1'b0;
    logic [3:0]  bus_we = 4'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] led_out;
    logic [15:0] sw_in = '0;
    logic        timer_irq;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem [0:4095];

    data_bus_hub dut (
        .clk(clk), .rst_n(rst_n), .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .led_out(led_out), .sw_in(sw_in), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_addr = a; bus_wdata = d; bus_we = we;
        @(posedge clk); #1;
        bus_we = 4'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a; bus_re = 1'b1;
        @(posedge clk); #1;
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        vectors++;
        if (bus_rdata !== 32'h0 || led_out !== 16'h0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h led=%h irq=%b, want 0/0/0", bus_rdata, led_out, timer_irq);
        end
        bus_read(PB + 32'h08, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(PB + 32'h0C, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", d); end
    endtask

    task automatic test_ram;
        logic [31:0] d;
        bus_write(32'h0, 32'h0, 4'hF);
        bus_addr = 32'h10; bus_wdata = 32'hDEAD_BEEF; bus_we = 4'hF;
        #1;
        vectors++;
        if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_addr !== 12'd4 || ram_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_drive: en=%b we=%h addr=%h wd=%h, want 1/F/004/deadbeef",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        @(posedge clk); #1;
        bus_we = 4'b0;
        bus_write(32'h14, 32'h1234_5678, 4'hF);
        // back-to-back reads, one result per cycle
        bus_re = 1'b1; bus_addr = 32'h10;
        @(posedge clk); #1;
        bus_addr = 32'h14;
        vectors++;
        if (bus_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_rt0: got %h want deadbeef", bus_rdata);
        end
        @(posedge clk); #1;
        bus_re = 1'b0;
        vectors++;
        if (bus_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_rt1: got %h want 12345678", bus_rdata);
        end
        bus_read(32'h4000_0000, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL ram_alias0: got %h want 0", d); end
    endtask

    task automatic test_led_lanes;
        logic [31:0] d;
        bus_write(PB, 32'h0000_A5A5, 4'b0001);
        vectors++;
        if (led_out !== 16'h00A5) begin errors++; $display("FAIL led_lane0: got %h want 00a5", led_out); end
        bus_read(PB, d);
        vectors++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL led_read: got %h want 000000a5", d); end
        bus_write(PB, 32'hFFFF_3C00, 4'b1110);
        vectors++;
        if (led_out !== 16'h3CA5) begin errors++; $display("FAIL led_lane1: got %h want 3ca5", led_out); end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        bus_addr = 32'h9000_0000; bus_wdata = 32'hFFFF_FFFF; bus_we = 4'hF;
        #1;
        vectors++;
        if (ram_en !== 1'b0 || ram_we !== 4'h0) begin
            errors++; $display("FAIL unmapped_ram: en=%b we=%h want 0/0", ram_en, ram_we);
        end
        @(posedge clk); #1;
        bus_we = 4'b0;
        bus_write(PB + 32'h40, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h9000_0000, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
        bus_read(PB + 32'h40, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL hole_read: got %h want 0", d); end
        vectors++;
        if (led_out !== 16'h3CA5) begin errors++; $display("FAIL led_untouched: got %h want 3ca5", led_out); end
    endtask

    task automatic test_switch_sync;
        logic [31:0] d;
        sw_in = 16'h1234;
        bus_read(PB + 32'h04, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL sw_lat1: got %h want 0", d); end
        bus_read(PB + 32'h04, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL sw_lat2: got %h want 0", d); end
        bus_read(PB + 32'h04, d);
        vectors++;
        if (d !== 32'h1234) begin errors++; $display("FAIL sw_lat3: got %h want 1234", d); end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        bus_write(PB + 32'h10, 32'd3, 4'hF);
        bus_write(PB + 32'h0C, 32'd0, 4'hF);
        bus_write(PB + 32'h08, 32'd7, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_early: irq=%b want 0", timer_irq); end
        @(posedge clk); #1;
        vectors++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_match: irq=%b want 1", timer_irq); end
        bus_read(PB + 32'h0C, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL timer_reload: cnt=%h want 0", d); end
        bus_write(PB + 32'h08, 32'd4, 4'hF);
        bus_read(PB + 32'h14, d);
        vectors++;
        if (d !== 32'h1) begin errors++; $display("FAIL stat_read: got %h want 1", d); end
        bus_write(PB + 32'h14, 32'h1, 4'h1);
        vectors++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL stat_w1c: irq=%b want 0", timer_irq); end
        bus_read(PB + 32'h0C, d);
        vectors++;
        if (d !== 32'h2) begin errors++; $display("FAIL timer_hold: cnt=%h want 2", d); end
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        bus_write(PB + 32'h0C, 32'd3, 4'hF);
        bus_write(PB + 32'h08, 32'd5, 4'hF);
        bus_write(PB + 32'h14, 32'h1, 4'h1);
        vectors++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_beats_w1c: irq=%b want 1", timer_irq); end
        bus_write(PB + 32'h0C, 32'h100, 4'hF);
        bus_write(PB + 32'h08, 32'd0, 4'hF);
        bus_read(PB + 32'h0C, d);
        vectors++;
        if (d !== 32'h101) begin errors++; $display("FAIL write_beats_tick: cnt=%h want 101", d); end
        bus_read(PB + 32'h14, d);
        vectors++;
        if (d !== 32'h1) begin errors++; $display("FAIL stat_after_collide: got %h want 1", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_write(PB + 32'h10, 32'd0, 4'hF);
        bus_write(PB + 32'h0C, 32'd0, 4'hF);
        bus_write(PB + 32'h08, 32'd5, 4'hF);
        bus_write(PB, 32'hFFFF, 4'h3);
        bus_re = 1'b1; bus_addr = 32'h10;
        @(posedge clk); #1;
        vectors++;
        if (bus_rdata !== 32'hDEAD_BEEF || timer_irq !== 1'b1 || led_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL pre_reset: rdata=%h irq=%b led=%h want deadbeef/1/ffff", bus_rdata, timer_irq, led_out);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_rdata !== 32'h0 || timer_irq !== 1'b0 || led_out !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: rdata=%h irq=%b led=%h want 0/0/0", bus_rdata, timer_irq, led_out);
        end
        bus_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL post_reset_rdata: got %h want 0", bus_rdata); end
        bus_read(PB + 32'h0C, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_cnt: got %h want 0", d); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_ram();
        test_led_lanes();
        test_unmapped();
        test_switch_sync();
        test_timer();
        test_collisions();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
